// File: rtl/pipe_skid_latch.sv
// rtl/pipe_skid_latch.sv - pipeline stage register with valid/ready handshake,
// one-entry skid buffer, synchronous flush and saturating stall/flush counters.
module pipe_skid_latch #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // State encoding is {skid_valid, main_valid}; the valid bits are the state.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        BAD   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;
    logic              load_main;
    logic              main_from_skid;
    logic              load_skid;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign main_valid = state[0];
    assign skid_valid = state[1];

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Squash wins over every transfer; data registers are left alone.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_main = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_nxt = FULL;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                BAD: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            main_data <= RESET_VAL;
            skid_data <= RESET_VAL;
        end else begin
            if (load_main) begin
                main_data <= main_from_skid ? skid_data : in_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (main_valid || skid_valid) && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_latch.sv
// tb/tb_pipe_skid_latch.sv - directed vector table, corner sequences and a
// queue reference model for pipe_skid_latch.
module tb_pipe_skid_latch;

    localparam int           DW    = 8;
    localparam int           CW    = 4;
    localparam logic [DW-1:0] RVAL = 8'h5A;

    logic          CLK;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic          cnt_clr;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int tests;
    int fails;

    pipe_skid_latch #(.DATA_W(DW), .RESET_VAL(RVAL), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          clr;
        logic          e_ov;
        logic          e_ir;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_stall;
        logic [CW-1:0] e_fc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy, logic fl, logic clr,
                                logic e_ov, logic e_ir, logic [DW-1:0] e_od,
                                logic [CW-1:0] e_stall, logic [CW-1:0] e_fc);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od; v.e_stall = e_stall; v.e_fc = e_fc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic ir, input logic [DW-1:0] od,
                           input logic [CW-1:0] st, input logic [CW-1:0] fc);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, " in_ready"},  64'(in_ready),  64'(ir));
        chk({tag, " out_data"},  64'(out_data),  64'(od));
        chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(st));
        chk({tag, " flush_cnt"}, 64'(flush_cnt), 64'(fc));
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl; cnt_clr = clr;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [DW-1:0] q[$];
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_fc;
    logic [DW-1:0] seq_d;
    logic          r_iv, r_or, r_fl, r_clr;
    logic          m_in_fire, m_out_fire;

    initial begin
        tests = 0;
        fails = 0;
        RST = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_all("reset", 1'b0, 1'b1, RVAL, 4'h0, 4'h0);
        #11;
        RST = 1'b0;

        // Streaming at full rate
        vecs.push_back(mk(1, 8'h01, 1, 0, 0,  1, 1, 8'h01, 0, 0));
        vecs.push_back(mk(1, 8'h02, 1, 0, 0,  1, 1, 8'h02, 0, 0));
        vecs.push_back(mk(1, 8'h03, 1, 0, 0,  1, 1, 8'h03, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0,  0, 1, 8'h03, 0, 0));
        // Backpressure into skid, then in-order drain
        vecs.push_back(mk(1, 8'h0A, 1, 0, 0,  1, 1, 8'h0A, 0, 0));
        vecs.push_back(mk(1, 8'h0B, 0, 0, 0,  1, 0, 8'h0A, 1, 0));
        vecs.push_back(mk(1, 8'h0C, 0, 0, 0,  1, 0, 8'h0A, 2, 0));
        vecs.push_back(mk(1, 8'h0C, 0, 0, 0,  1, 0, 8'h0A, 3, 0));
        vecs.push_back(mk(1, 8'h0C, 1, 0, 0,  1, 1, 8'h0B, 3, 0));
        vecs.push_back(mk(1, 8'h0C, 1, 0, 0,  1, 1, 8'h0C, 3, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0,  0, 1, 8'h0C, 3, 0));
        // Flush from FULL with a concurrent offer, then flush while EMPTY
        vecs.push_back(mk(1, 8'h0A, 0, 0, 0,  1, 1, 8'h0A, 3, 0));
        vecs.push_back(mk(1, 8'h0B, 0, 0, 0,  1, 0, 8'h0A, 4, 0));
        vecs.push_back(mk(1, 8'h0D, 0, 1, 0,  0, 1, 8'h0A, 5, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0,  0, 1, 8'h0A, 5, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1,  0, 1, 8'h0A, 0, 0));
        // Flush in ONE discards a simultaneous accept; clear overrides a flush count
        vecs.push_back(mk(1, 8'h11, 1, 0, 0,  1, 1, 8'h11, 0, 0));
        vecs.push_back(mk(1, 8'h22, 1, 1, 0,  0, 1, 8'h11, 0, 1));
        vecs.push_back(mk(1, 8'h33, 1, 0, 0,  1, 1, 8'h33, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1,  0, 1, 8'h33, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_od,
                    vecs[i].e_stall, vecs[i].e_fc);
        end

        // Stall counter saturation and clear-over-increment
        drive(1, 8'h44, 0, 0, 0);
        step();
        drive(0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 21; i++) begin
            step();
            if (i == 14) chk("stall_14", 64'(stall_cnt), 64'hE);
            if (i == 15) chk("stall_15", 64'(stall_cnt), 64'hF);
        end
        chk("stall_sat", 64'(stall_cnt), 64'hF);
        chk("stall_sat_ov", 64'(out_valid), 64'h1);
        drive(0, 8'h00, 0, 0, 1);
        step();
        chk("stall_clr", 64'(stall_cnt), 64'h0);
        drive(0, 8'h00, 0, 0, 0);
        step();
        chk("stall_after_clr", 64'(stall_cnt), 64'h1);
        drive(0, 8'h00, 1, 0, 0);
        step();
        chk("drain_ov", 64'(out_valid), 64'h0);

        // Asynchronous reset while FULL
        drive(0, 8'h00, 0, 0, 1);
        step();
        drive(1, 8'h61, 0, 0, 0);
        step();
        drive(1, 8'h62, 0, 0, 0);
        step();
        chk_all("prereset", 1'b1, 1'b0, 8'h61, 4'h1, 4'h0);
        drive(0, 8'h00, 0, 0, 0);
        #2;
        RST = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b1, RVAL, 4'h0, 4'h0);
        #2;
        RST = 1'b0;

        // Random traffic against a queue model
        m_stall = '0;
        m_fc    = '0;
        seq_d   = 8'h80;
        step();
        for (int c = 0; c < 10000; c++) begin
            r_iv  = ($urandom_range(0, 9) < 7);
            r_or  = ($urandom_range(0, 9) < 6);
            r_fl  = ($urandom_range(0, 19) == 0);
            r_clr = ($urandom_range(0, 99) == 0);
            drive(r_iv, seq_d, r_or, r_fl, r_clr);
            m_in_fire  = r_iv && (q.size() < 2);
            m_out_fire = (q.size() > 0) && r_or;
            if (r_clr) begin
                m_stall = '0;
                m_fc    = '0;
            end else begin
                if (q.size() > 0 && !r_or && m_stall != 4'hF) m_stall++;
                if (r_fl && q.size() > 0 && m_fc != 4'hF) m_fc++;
            end
            if (r_fl) begin
                q.delete();
            end else begin
                if (m_out_fire) void'(q.pop_front());
                if (m_in_fire) q.push_back(seq_d);
            end
            seq_d++;
            step();
            chk($sformatf("rnd%0d out_valid", c), 64'(out_valid), 64'(q.size() > 0));
            chk($sformatf("rnd%0d in_ready", c),  64'(in_ready),  64'(q.size() < 2));
            if (q.size() > 0) chk($sformatf("rnd%0d out_data", c), 64'(out_data), 64'(q[0]));
            chk($sformatf("rnd%0d stall_cnt", c), 64'(stall_cnt), 64'(m_stall));
            chk($sformatf("rnd%0d flush_cnt", c), 64'(flush_cnt), 64'(m_fc));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_skid_latch.md
Name: pipe_skid_latch

Overview:
Parametrised pipeline stage register for inter-stage latches (IF/ID, ID/EX, ...). Replaces the bare enable-gated latch with a valid/ready handshake, a one-entry skid buffer and a synchronous flush for branch and jump squash. Two saturating performance counters record backpressure and squash events. One instance sits between each pair of pipeline stages; payload width is set per instance.

Parameters:
DATA_W, 64, payload width in bits (e.g. NPC concatenated with the instruction word).
RESET_VAL, '0, payload value loaded into both data registers on reset.
CNT_W, 16, width of each performance counter.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
in_valid  in  1  upstream presents in_data
in_ready  out  1  stage can accept; registered, equals ~skid_valid
in_data  in  DATA_W  upstream payload
out_valid  out  1  out_data holds a live entry
out_ready  in  1  downstream accepts out_data this cycle
out_data  out  DATA_W  payload at head of stage
flush  in  1  squash all held entries at next edge
cnt_clr  in  1  synchronous clear of both counters
stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready
flush_cnt  out  CNT_W  flushes that discarded at least one valid entry

Behaviour:
- Reset (RST=1, async): main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1. main_data=skid_data=RESET_VAL and counters=0. Reset asserted mid-transfer drops all entries, with no partial state.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. out_valid=main_valid, out_data=main_data, in_ready=~skid_valid. There are no combinational paths from inputs to outputs.
- States {skid_valid, main_valid}:
  - EMPTY 00
    - in_fire: load main, go to ONE. Latency is 1 cycle from in_fire to out_valid.
  - ONE 01
    - in_fire & out_fire: main <= in_data, stay in ONE.
    - in_fire & ~out_fire: skid <= in_data, go to FULL.
    - ~in_fire & out_fire: go to EMPTY.
    - Otherwise: hold.
  - FULL 11 (in_ready=0, so in_fire is impossible)
    - out_fire: main <= skid, skid_valid=0, go to ONE.
    - Otherwise: hold.
  - State 10 is unreachable. If it is ever entered, the next edge forces EMPTY.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- Throughput is 1 entry per cycle with out_ready held high. A single out_ready low cycle is absorbed by the skid without deasserting in_ready in that same cycle.
- Flush has priority over all transfers in its cycle: next state is EMPTY, and any in_fire in the flush cycle is discarded. Data registers are not cleared; only the valid bits clear. Since in_ready stays registered, upstream sees in_ready=1 the cycle after a flush.
- Flush while EMPTY is legal: no state change, flush_cnt not incremented.
- stall_cnt: +1 each cycle with out_valid & ~out_ready, saturating at all-ones.
- flush_cnt: +1 on flush & (main_valid | skid_valid), saturating at all-ones.
- cnt_clr: counters become 0 at the next edge and override an increment in the same cycle.
- Data registers update only on the transfers listed above; they hold otherwise (X-free, no unnecessary toggling).

Test Plan:
1. Release reset, drive in_valid=1 with 0x1, 0x2, 0x3 on consecutive cycles, out_ready=1 -> out_valid rises 1 cycle after the first accept; out_data = 0x1, 0x2, 0x3 on consecutive cycles; in_ready stays 1.
2. ONE holding 0xA; drop out_ready for 3 cycles while offering 0xB, 0xC -> 0xB goes to skid and in_ready=0 from the next cycle; 0xC is not accepted; stall_cnt=3. Raise out_ready -> out_data 0xA, then 0xB, then 0xC, in order.
3. FULL (0xA main, 0xB skid), assert flush with in_valid=1, in_data=0xD -> next cycle out_valid=0, in_ready=1, 0xD lost, flush_cnt=1. Flush again while EMPTY -> flush_cnt stays 1.
4. Hold out_ready=0 with out_valid=1 for 2^CNT_W+5 cycles (CNT_W=4) -> stall_cnt saturates at 0xF. Assert cnt_clr together with a stall cycle -> stall_cnt=0.
5. Assert RST asynchronously mid-cycle while FULL -> out_valid=0, in_ready=1 and out_data=RESET_VAL immediately, without waiting for a CLK edge; counters=0.
6. Random in_valid/out_ready/flush for 10k cycles against a reference queue model -> delivered sequence equals accepted minus flushed entries; never more than 2 entries held.
